// File: rtl/shift_reg_engine.sv
// shift_reg_engine: four-mode shift register engine (PIPO, PISO, SIPO, SISO).
// Each start-triggered frame reports busy during shifting and a one-cycle done
// pulse at the end. Mode and bit order are latched when a frame is accepted.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     frame request, accepted in IDLE or DONE
//   mode      00=PIPO 01=PISO 10=SIPO 11=SISO
//   msb_first 1=MSB shifted first, 0=LSB first
//   par_in    parallel load data (PIPO, PISO)
//   ser_in    serial data in (SIPO, SISO)
//   ser_out   serial data out (PISO, SISO during SHIFT)
//   par_out   parallel result register (PIPO load, SIPO completion)
//   busy      frame in progress
//   done      one-cycle end-of-frame pulse
//   parity    (SHREG_PARITY_EN only) XOR of the last completed frame's data
//
// Optional feature macro: SHREG_PARITY_EN
module shift_reg_engine #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             msb_first,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] par_out,
  output logic             busy,
  output logic             done
`ifdef SHREG_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
`ifdef SHREG_PARITY_EN
    S_PAR,
`endif
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    M_PIPO = 2'b00,
    M_PISO = 2'b01,
    M_SIPO = 2'b10,
    M_SISO = 2'b11
  } mode_e;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic               msb_q, msb_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   par_out_q, par_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SHREG_PARITY_EN
  logic               parity_q, parity_d;
  logic               par_pend_q, par_pend_d;
`endif

  logic               shift_bit;
  logic [WIDTH-1:0]   shifted;
  logic               last_bit;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    msb_d     = msb_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    par_out_d = par_out_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
`ifdef SHREG_PARITY_EN
    parity_d   = parity_q;
    par_pend_d = par_pend_q;
`endif

    // PISO drains the register with zeros; the serial-input modes take ser_in.
    shift_bit = (mode_q == M_PISO) ? 1'b0 : ser_in;
    shifted   = msb_q ? {sreg_q[WIDTH-2:0], shift_bit}
                      : {shift_bit, sreg_q[WIDTH-1:1]};
    last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    case (state_q)
      // DONE accepts start exactly like IDLE so frames can run back to back.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          mode_d = mode_e'(mode);
          msb_d  = msb_first;
          cnt_d  = '0;
          case (mode_e'(mode))
            M_PIPO: begin
              sreg_d    = par_in;
              par_out_d = par_in;
              state_d   = S_DONE;
              done_d    = 1'b1;
`ifdef SHREG_PARITY_EN
              parity_d  = ^par_in;
`endif
            end
            M_PISO: begin
              sreg_d  = par_in;
              state_d = S_SHIFT;
              busy_d  = 1'b1;
`ifdef SHREG_PARITY_EN
              par_pend_d = ^par_in;
`endif
            end
            default: begin
              state_d = S_SHIFT;
              busy_d  = 1'b1;
            end
          endcase
        end
      end
      S_SHIFT: begin
        sreg_d = shifted;
        if (last_bit) begin
          cnt_d = '0;
          if (mode_q == M_SIPO) begin
            par_out_d = shifted;
`ifdef SHREG_PARITY_EN
            parity_d  = ^shifted;
`endif
          end
`ifdef SHREG_PARITY_EN
          if (mode_q == M_PISO) begin
            state_d = S_PAR;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end
`ifdef SHREG_PARITY_EN
      // Extra PISO bit slot carrying the parity of the loaded word.
      S_PAR: begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        parity_d = par_pend_q;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= M_PIPO;
      msb_q     <= 1'b0;
      sreg_q    <= '0;
      cnt_q     <= '0;
      par_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SHREG_PARITY_EN
      parity_q   <= 1'b0;
      par_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      msb_q     <= msb_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      par_out_q <= par_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SHREG_PARITY_EN
      parity_q   <= parity_d;
      par_pend_q <= par_pend_d;
`endif
    end
  end

  always_comb begin
    ser_out = 1'b0;
    if (state_q == S_SHIFT && (mode_q == M_PISO || mode_q == M_SISO)) begin
      ser_out = msb_q ? sreg_q[WIDTH-1] : sreg_q[0];
    end
`ifdef SHREG_PARITY_EN
    if (state_q == S_PAR) begin
      ser_out = par_pend_q;
    end
`endif
  end

  assign par_out = par_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef SHREG_PARITY_EN
  assign parity  = parity_q;
`endif

endmodule

// File: tb/tb_shift_reg_engine.sv
// Testbench for shift_reg_engine (WIDTH=4): directed scenarios plus randomized
// frames checked against a frame-level reference model. Build with
// +define+SHREG_PARITY_EN to cover the parity variant.
module tb_shift_reg_engine;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic         msb_first;
  logic [W-1:0] par_in;
  logic         ser_in;
  logic         ser_out;
  logic [W-1:0] par_out;
  logic         busy;
  logic         done;
`ifdef SHREG_PARITY_EN
  logic         parity;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: register contents, parallel result and parity as values.
  logic [W-1:0] m_sreg;
  logic [W-1:0] m_par_out;
  logic         m_parity;

  always #5 clk = ~clk;

  shift_reg_engine #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .msb_first(msb_first),
    .par_in   (par_in),
    .ser_in   (ser_in),
    .ser_out  (ser_out),
    .par_out  (par_out),
    .busy     (busy),
    .done     (done)
`ifdef SHREG_PARITY_EN
    ,
    .parity   (parity)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bit k of a word in shift order.
  function automatic logic pick(input logic [W-1:0] v, input int unsigned k, input logic msb);
    return msb ? v[W-1-k] : v[k];
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    m_sreg = '0;
    m_par_out = '0;
    m_parity = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    mode = 2'b00;
    par_in = 4'b1111;
    tick;
    tick;
    rst = 1'b0;
    start = 1'b0;
    m_sreg = '0;
    m_par_out = '0;
    m_parity = 1'b0;
    total++;
    if ({busy, done, ser_out, par_out} !== {1'b0, 1'b0, 1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", {busy, done, ser_out, par_out}, 7'b0);
    end
`ifdef SHREG_PARITY_EN
    total++;
    if (parity !== 1'b0) begin
      bad++;
      $display("FAIL reset_parity got=%b want=0", parity);
    end
`endif
  endtask

  task automatic test_pipo;
    mode = 2'b00;
    msb_first = 1'b1;
    par_in = 4'b1011;
    start = 1'b1;
    tick;
    start = 1'b0;
    par_in = 4'b0000;
    total++;
    if ({busy, done, ser_out, par_out} !== {1'b0, 1'b1, 1'b0, 4'b1011}) begin
      bad++;
      $display("FAIL pipo_load got=%b want=%b", {busy, done, ser_out, par_out}, 7'b0101011);
    end
    tick;
    total++;
    if ({busy, done, ser_out, par_out} !== {1'b0, 1'b0, 1'b0, 4'b1011}) begin
      bad++;
      $display("FAIL pipo_hold got=%b want=%b", {busy, done, ser_out, par_out}, 7'b0001011);
    end
    m_sreg = 4'b1011;
    m_par_out = 4'b1011;
    m_parity = 1'b1;
  endtask

  task automatic test_piso;
    logic [W-1:0] pv;
    logic         msb;
    pv = 4'b1011;
    for (int m = 1; m >= 0; m--) begin
      msb = 1'(m);
      mode = 2'b01;
      msb_first = msb;
      par_in = pv;
      start = 1'b1;
      tick;
      start = 1'b0;
      par_in = ~pv;
      mode = 2'b10;
      msb_first = ~msb;
      for (int unsigned k = 0; k < W; k++) begin
        total++;
        if ({busy, done, ser_out, par_out} !== {1'b1, 1'b0, pick(pv, k, msb), m_par_out}) begin
          bad++;
          $display("FAIL piso_bit msb=%0b k=%0d got=%b want=%b", msb, k,
                   {busy, done, ser_out, par_out}, {1'b1, 1'b0, pick(pv, k, msb), m_par_out});
        end
        tick;
      end
`ifdef SHREG_PARITY_EN
      total++;
      if ({busy, done, ser_out} !== {1'b1, 1'b0, ^pv}) begin
        bad++;
        $display("FAIL piso_parity_slot got=%b want=%b", {busy, done, ser_out}, {1'b1, 1'b0, ^pv});
      end
      tick;
      m_parity = ^pv;
      total++;
      if (parity !== m_parity) begin
        bad++;
        $display("FAIL piso_parity got=%b want=%b", parity, m_parity);
      end
`endif
      total++;
      if ({busy, done, ser_out, par_out} !== {1'b0, 1'b1, 1'b0, m_par_out}) begin
        bad++;
        $display("FAIL piso_done got=%b want=%b", {busy, done, ser_out, par_out},
                 {1'b0, 1'b1, 1'b0, m_par_out});
      end
      tick;
      m_sreg = '0;
    end
  endtask

  task automatic test_sipo;
    logic [W-1:0] bits;
    do_reset;
    bits = 4'b1011;
    mode = 2'b10;
    msb_first = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int unsigned k = 0; k < W; k++) begin
      ser_in = pick(bits, k, 1'b0);
      total++;
      if ({busy, done, ser_out, par_out} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
        bad++;
        $display("FAIL sipo_shift k=%0d got=%b want=%b", k, {busy, done, ser_out, par_out}, 7'b1000000);
      end
      tick;
    end
    total++;
    if ({busy, done, ser_out, par_out} !== {1'b0, 1'b1, 1'b0, 4'b1011}) begin
      bad++;
      $display("FAIL sipo_done got=%b want=%b", {busy, done, ser_out, par_out}, 7'b0101011);
    end
`ifdef SHREG_PARITY_EN
    total++;
    if (parity !== 1'b1) begin
      bad++;
      $display("FAIL sipo_parity got=%b want=1", parity);
    end
`endif
    tick;
    m_sreg = 4'b1011;
    m_par_out = 4'b1011;
    m_parity = 1'b1;
  endtask

  task automatic test_siso_back_to_back;
    logic [W-1:0] in1;
    do_reset;
    in1 = 4'b1011;
    mode = 2'b11;
    msb_first = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int unsigned k = 0; k < W; k++) begin
      ser_in = pick(in1, k, 1'b1);
      total++;
      if ({busy, done, ser_out} !== {1'b1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL siso_first k=%0d got=%b want=100", k, {busy, done, ser_out});
      end
      tick;
    end
    total++;
    if ({busy, done, ser_out} !== {1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL siso_done1 got=%b want=010", {busy, done, ser_out});
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int unsigned k = 0; k < W; k++) begin
      ser_in = 1'b0;
      total++;
      if ({busy, done, ser_out} !== {1'b1, 1'b0, pick(in1, k, 1'b1)}) begin
        bad++;
        $display("FAIL siso_second k=%0d got=%b want=%b", k, {busy, done, ser_out},
                 {1'b1, 1'b0, pick(in1, k, 1'b1)});
      end
      tick;
    end
    total++;
    if ({busy, done, ser_out, par_out} !== {1'b0, 1'b1, 1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL siso_done2 got=%b want=%b", {busy, done, ser_out, par_out}, 7'b0100000);
    end
    tick;
    m_sreg = '0;
  endtask

  task automatic test_robust;
    logic [W-1:0] pv;
    pv = 4'b0110;
    mode = 2'b01;
    msb_first = 1'b1;
    par_in = pv;
    start = 1'b1;
    tick;
    for (int unsigned k = 0; k < W; k++) begin
      start = (k == 1);
      total++;
      if ({busy, done, ser_out} !== {1'b1, 1'b0, pick(pv, k, 1'b1)}) begin
        bad++;
        $display("FAIL robust_piso k=%0d got=%b want=%b", k, {busy, done, ser_out},
                 {1'b1, 1'b0, pick(pv, k, 1'b1)});
      end
      tick;
    end
    start = 1'b0;
`ifdef SHREG_PARITY_EN
    tick;
`endif
    total++;
    if ({busy, done} !== 2'b01) begin
      bad++;
      $display("FAIL robust_done got=%b want=01", {busy, done});
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({busy, done, ser_out} !== 3'b000) begin
        bad++;
        $display("FAIL robust_no_second got=%b want=000", {busy, done, ser_out});
      end
    end
    // Give par_out a nonzero value so the abort check can see it cleared.
    mode = 2'b00;
    par_in = 4'b1001;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    mode = 2'b01;
    par_in = 4'b1111;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if ({busy, done, ser_out, par_out} !== {1'b0, 1'b0, 1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL abort_state got=%b want=%b", {busy, done, ser_out, par_out}, 7'b0);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if ({busy, done, ser_out} !== 3'b000) begin
        bad++;
        $display("FAIL abort_quiet got=%b want=000", {busy, done, ser_out});
      end
    end
    rst = 1'b1;
    start = 1'b1;
    mode = 2'b00;
    par_in = 4'b1111;
    tick;
    rst = 1'b0;
    start = 1'b0;
    total++;
    if ({busy, done, par_out} !== {1'b0, 1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL rst_wins got=%b want=%b", {busy, done, par_out}, 6'b0);
    end
    m_sreg = '0;
    m_par_out = '0;
    m_parity = 1'b0;
  endtask

`ifdef SHREG_PARITY_EN
  task automatic test_parity;
    logic [W-1:0] vals [2];
    vals[0] = 4'b1011;
    vals[1] = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      mode = 2'b00;
      par_in = vals[i];
      start = 1'b1;
      tick;
      start = 1'b0;
      total++;
      if ({done, parity} !== {1'b1, ^vals[i]}) begin
        bad++;
        $display("FAIL pipo_parity i=%0d got=%b want=%b", i, {done, parity}, {1'b1, ^vals[i]});
      end
      tick;
    end
    m_sreg = 4'b0101;
    m_par_out = 4'b0101;
    m_parity = 1'b0;
  endtask
`endif

  task automatic test_random;
    logic [1:0]   fm;
    logic         fmsb;
    logic [W-1:0] fpar;
    logic [W-1:0] sin_v;
    logic         b;
    logic         exp_s;
    for (int f = 0; f < 60; f++) begin
      fm = 2'($urandom_range(0, 3));
      fmsb = 1'($urandom_range(0, 1));
      fpar = W'($urandom);
      mode = fm;
      msb_first = fmsb;
      par_in = fpar;
      start = 1'b1;
      tick;
      start = 1'b0;
      if (fm == 2'b00) begin
        m_sreg = fpar;
        m_par_out = fpar;
        m_parity = ^fpar;
      end else begin
        sin_v = '0;
        for (int unsigned k = 0; k < W; k++) begin
          b = 1'($urandom_range(0, 1));
          ser_in = b;
          if (fmsb) sin_v[W-1-k] = b;
          else sin_v[k] = b;
          start = 1'($urandom_range(0, 1));
          mode = 2'($urandom_range(0, 3));
          msb_first = 1'($urandom_range(0, 1));
          par_in = W'($urandom);
          case (fm)
            2'b01:   exp_s = pick(fpar, k, fmsb);
            2'b11:   exp_s = pick(m_sreg, k, fmsb);
            default: exp_s = 1'b0;
          endcase
          total++;
          if ({busy, done, ser_out, par_out} !== {1'b1, 1'b0, exp_s, m_par_out}) begin
            bad++;
            $display("FAIL rand_shift f=%0d mode=%0d k=%0d got=%b want=%b", f, fm, k,
                     {busy, done, ser_out, par_out}, {1'b1, 1'b0, exp_s, m_par_out});
          end
          tick;
        end
`ifdef SHREG_PARITY_EN
        if (fm == 2'b01) begin
          total++;
          if ({busy, done, ser_out} !== {1'b1, 1'b0, ^fpar}) begin
            bad++;
            $display("FAIL rand_parity_slot f=%0d got=%b want=%b", f, {busy, done, ser_out},
                     {1'b1, 1'b0, ^fpar});
          end
          tick;
        end
`endif
        case (fm)
          2'b01: begin
            m_sreg = '0;
            m_parity = ^fpar;
          end
          2'b10: begin
            m_sreg = sin_v;
            m_par_out = sin_v;
            m_parity = ^sin_v;
          end
          default: m_sreg = sin_v;
        endcase
      end
      total++;
      if ({busy, done, ser_out, par_out} !== {1'b0, 1'b1, 1'b0, m_par_out}) begin
        bad++;
        $display("FAIL rand_done f=%0d mode=%0d got=%b want=%b", f, fm,
                 {busy, done, ser_out, par_out}, {1'b0, 1'b1, 1'b0, m_par_out});
      end
`ifdef SHREG_PARITY_EN
      total++;
      if (parity !== m_parity) begin
        bad++;
        $display("FAIL rand_parity f=%0d got=%b want=%b", f, parity, m_parity);
      end
`endif
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b0;
        tick;
        total++;
        if ({busy, done, ser_out, par_out} !== {1'b0, 1'b0, 1'b0, m_par_out}) begin
          bad++;
          $display("FAIL rand_idle f=%0d got=%b want=%b", f, {busy, done, ser_out, par_out},
                   {1'b0, 1'b0, 1'b0, m_par_out});
        end
      end
    end
    start = 1'b0;
    tick;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 2'b00;
    msb_first = 1'b0;
    par_in = '0;
    ser_in = 1'b0;
    m_sreg = '0;
    m_par_out = '0;
    m_parity = 1'b0;
    test_reset;
    test_pipo;
    test_piso;
    test_sipo;
    test_siso_back_to_back;
    test_robust;
`ifdef SHREG_PARITY_EN
    test_parity;
`endif
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
